// File: rtl/falconsoar_pkg.sv
// Shared types and constants for the split/merge job sequencer.
package falconsoar_pkg;

    localparam int MEM_ADDR_BITS  = 6;
    localparam int TASK_REDUCE_BW = 16 + 3 * MEM_ADDR_BITS;

    typedef logic [MEM_ADDR_BITS-1:0] mem_addr_t;

    // split_merge_top task type codes
    localparam logic [2:0] SPLIT_256 = 3'd2;
    localparam logic [2:0] MERGE_256 = 3'd3;
    localparam logic [2:0] SPLIT_512 = 3'd4;
    localparam logic [2:0] MERGE_512 = 3'd5;

    localparam logic [1:0] FFT_MODE  = 2'b00;
    localparam logic [4:0] STAGE_MAX = 5'd8;

    // bit of the task word carrying output_position_set
    localparam int POS_OUT_BIT = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } seq_state_e;

    // Task type from job flavour: {n512,merge} + 2
    function automatic logic [2:0] task_type(input logic n512, input logic merge);
        logic [2:0] t;
        if (n512) t = merge ? MERGE_512 : SPLIT_512;
        else      t = merge ? MERGE_256 : SPLIT_256;
        return t;
    endfunction

endpackage

// File: rtl/counter_ce.sv
// Saturating up-counter with synchronous clear and count enable.
module counter_ce #(
    parameter int           W   = 12,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ce,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    // clear wins over enable; hold at MAX once reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr)                      cnt_d = '0;
        else if (ce && cnt_q != MAX)  cnt_d = cnt_q + 1'b1;
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/split_merge_seq_ctrl_task_word_pack.sv
// Packs task fields into the split_merge_top input_task word layout.
module sm_task_word_pack
    import falconsoar_pkg::*;
(
    input  logic [4:0]                stage,
    input  logic [2:0]                ttype,
    input  logic                      in_pos,
    input  logic                      out_pos,
    input  mem_addr_t                 b0,
    input  mem_addr_t                 b1,
    input  mem_addr_t                 b2,
    output logic [TASK_REDUCE_BW-1:0] word
);

    // {b0,b1,b2} | stage[15:11] | type[10:8] | mode[7:6] | out[5] | in[4] | 0[3:0]
    assign word = {b0, b1, b2, stage, ttype, FFT_MODE, out_pos, in_pos, 4'b0000};

endmodule

// File: rtl/split_merge_seq_ctrl.sv
// Expands one split/merge job into per-stage tasks for split_merge_top,
// with ping-pong addressing, inter-task gap and a per-task watchdog.
module split_merge_seq_ctrl
    import falconsoar_pkg::*;
#(
    parameter int WDOG_CYCLES = 4096,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_merge,
    input  logic                       cmd_n512,
    input  logic [4:0]                 cmd_stage_hi,
    input  logic [4:0]                 cmd_stage_lo,
    input  logic                       cmd_in_neg,
    input  logic                       cmd_out_neg,
    input  logic [3*MEM_ADDR_BITS-1:0] cmd_addr,
    output logic                       task_start,
    output logic [TASK_REDUCE_BW-1:0]  task_word,
    input  logic                       task_done,
    output logic                       busy,
    output logic                       job_done,
    output logic                       job_err
);

    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam int M = MEM_ADDR_BITS;

    seq_state_e state_q, state_d;

    logic [4:0]         stage_q, stage_d;
    logic               odd_q, odd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [4:0]         hi_q, hi_d, lo_q, lo_d;
    logic               merge_q, merge_d, n512_q, n512_d, out_neg_q, out_neg_d;
    logic [3*M-1:0]     addr_q, addr_d;
    logic [TASK_REDUCE_BW-1:0] word_q, word_d;

    logic               hs, cmd_illegal, is_last;
    logic [WDOG_W-1:0]  wdog;

    // next-task candidate fields
    logic               src_merge, src_n512, src_out_neg;
    logic [4:0]         src_hi, src_lo, nxt_stage;
    logic [3*M-1:0]     src_addr, nxt_addr;
    logic               nxt_odd, nxt_last, nxt_in, nxt_out;
    logic [TASK_REDUCE_BW-1:0] nxt_word;

    assign hs          = (state_q == IDLE) && cmd_valid;
    assign cmd_illegal = (cmd_stage_lo > cmd_stage_hi) || (cmd_stage_hi > STAGE_MAX) ||
                         ((cmd_stage_hi == STAGE_MAX) && !cmd_n512);
    assign is_last     = (stage_q == (merge_q ? hi_q : lo_q));

    // Watchdog runs from the start cycle so expiry lands WDOG_CYCLES after the pulse
    counter_ce #(.W(WDOG_W), .MAX(WDOG_LAST)) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!(state_q == ISSUE || state_q == WAIT)),
        .ce    (state_q == ISSUE || state_q == WAIT),
        .cnt   (wdog)
    );

    // FSM next state; completion beats watchdog expiry in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cmd_valid) state_d = cmd_illegal ? ERR : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (task_done)              state_d = is_last ? DONE : GAP;
                else if (wdog == WDOG_LAST) state_d = ERR;
            end
            GAP:   if (gap_q == GAP_LAST) state_d = ISSUE;
            DONE:  state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next task: first task from the live command, later tasks step from the captured one
    always_comb begin
        src_merge   = (state_q == IDLE) ? cmd_merge    : merge_q;
        src_n512    = (state_q == IDLE) ? cmd_n512     : n512_q;
        src_out_neg = (state_q == IDLE) ? cmd_out_neg  : out_neg_q;
        src_hi      = (state_q == IDLE) ? cmd_stage_hi : hi_q;
        src_lo      = (state_q == IDLE) ? cmd_stage_lo : lo_q;
        src_addr    = (state_q == IDLE) ? cmd_addr     : addr_q;
        if (state_q == IDLE) begin
            nxt_stage = cmd_merge ? cmd_stage_lo : cmd_stage_hi;
            nxt_odd   = 1'b0;
            nxt_in    = cmd_in_neg;
        end else begin
            nxt_stage = merge_q ? 5'(stage_q + 5'd1) : 5'(stage_q - 5'd1);
            nxt_odd   = ~odd_q;
            nxt_in    = word_q[POS_OUT_BIT];
        end
        nxt_last = (nxt_stage == (src_merge ? src_hi : src_lo));
        nxt_out  = nxt_last & src_out_neg;
        // odd tasks swap source and destination
        nxt_addr = nxt_odd ? {src_addr[M-1:0], src_addr[2*M-1:M], src_addr[3*M-1:2*M]}
                           : src_addr;
    end

    sm_task_word_pack u_pack (
        .stage   (nxt_stage),
        .ttype   (task_type(src_n512, src_merge)),
        .in_pos  (nxt_in),
        .out_pos (nxt_out),
        .b0      (mem_addr_t'(nxt_addr[3*M-1:2*M])),
        .b1      (mem_addr_t'(nxt_addr[2*M-1:M])),
        .b2      (mem_addr_t'(nxt_addr[M-1:0])),
        .word    (nxt_word)
    );

    // Datapath updates: capture on handshake, task word only on entry to ISSUE
    always_comb begin
        stage_d   = stage_q;
        odd_d     = odd_q;
        word_d    = word_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        merge_d   = merge_q;
        n512_d    = n512_q;
        out_neg_d = out_neg_q;
        addr_d    = addr_q;
        gap_d     = (state_q == GAP) ? GAP_W'(gap_q + 1'b1) : '0;
        if (hs) begin
            hi_d      = cmd_stage_hi;
            lo_d      = cmd_stage_lo;
            merge_d   = cmd_merge;
            n512_d    = cmd_n512;
            out_neg_d = cmd_out_neg;
            addr_d    = cmd_addr;
        end
        if (state_d == ISSUE && state_q != ISSUE) begin
            stage_d = nxt_stage;
            odd_d   = nxt_odd;
            word_d  = nxt_word;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            odd_q     <= 1'b0;
            gap_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            merge_q   <= 1'b0;
            n512_q    <= 1'b0;
            out_neg_q <= 1'b0;
            addr_q    <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            odd_q     <= odd_d;
            gap_q     <= gap_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            merge_q   <= merge_d;
            n512_q    <= n512_d;
            out_neg_q <= out_neg_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
        end
    end

    // Moore outputs decoded from state
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        task_start = (state_q == ISSUE);
        busy       = (state_q != IDLE);
        job_done   = (state_q == DONE);
        job_err    = (state_q == ERR);
    end

    assign task_word = word_q;

endmodule

// File: tb/tb_split_merge_seq_ctrl.sv
// Directed bench for split_merge_seq_ctrl.
module tb_split_merge_seq_ctrl;

    localparam int M  = 6;
    localparam int BW = 16 + 3 * M;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_merge, cmd_n512, cmd_in_neg, cmd_out_neg;
    logic [4:0]    cmd_stage_hi, cmd_stage_lo;
    logic [3*M-1:0] cmd_addr;
    logic          task_start, task_done, busy, job_done, job_err;
    logic [BW-1:0] task_word;

    int  errors = 0;
    int  checks = 0;
    int  start_cnt = 0;
    int  s0;
    bit  hold_valid = 1'b0;

    localparam logic [5:0] A = 6'h11, B = 6'h22, C = 6'h33;

    split_merge_seq_ctrl #(.WDOG_CYCLES(16), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_merge(cmd_merge), .cmd_n512(cmd_n512),
        .cmd_stage_hi(cmd_stage_hi), .cmd_stage_lo(cmd_stage_lo),
        .cmd_in_neg(cmd_in_neg), .cmd_out_neg(cmd_out_neg), .cmd_addr(cmd_addr),
        .task_start(task_start), .task_word(task_word), .task_done(task_done),
        .busy(busy), .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (task_start) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [BW-1:0] w(input logic [4:0] st, input logic [2:0] ty,
                                        input logic p5, input logic p4,
                                        input logic [5:0] b0, input logic [5:0] b1,
                                        input logic [5:0] b2);
        return {b0, b1, b2, st, ty, 2'b00, p5, p4, 4'b0000};
    endfunction

    // Handshake at the current negedge; returns at the negedge after acceptance
    task automatic send_cmd(input logic mg, input logic n5, input logic [4:0] hi,
                            input logic [4:0] lo, input logic in_n, input logic out_n,
                            input logic [3*M-1:0] ad);
        cmd_merge = mg; cmd_n512 = n5; cmd_stage_hi = hi; cmd_stage_lo = lo;
        cmd_in_neg = in_n; cmd_out_neg = out_n; cmd_addr = ad; cmd_valid = 1'b1;
        chk("cmd_ready_before_hs", cmd_ready, 1);
        tick();
        if (!hold_valid) cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (task_start) begin ok = 1'b1; break; end
            tick();
        end
        chk({tag, "_start_seen"}, ok, 1);
    endtask

    // One task: check word at start, answer op_done 10 cycles later
    task automatic do_task(input string tag, input logic [BW-1:0] exp,
                           input bit last, input bit spur);
        wait_start(tag);
        chk({tag, "_word"}, task_word, exp);
        repeat (9) tick();
        chk({tag, "_word_hold"}, task_word, exp);
        task_done = 1'b1;
        tick();
        if (last) chk({tag, "_job_done"}, job_done, 1);
        else      chk({tag, "_gap_busy"}, {busy, job_done, task_start}, 3'b100);
        if (spur) tick();
        task_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; task_done = 1'b0;
        cmd_merge = 1'b0; cmd_n512 = 1'b0; cmd_stage_hi = '0; cmd_stage_lo = '0;
        cmd_in_neg = 1'b0; cmd_out_neg = 1'b0; cmd_addr = '0;
        #3;
        chk("reset_outs", {cmd_ready, task_start, busy, job_done, job_err}, 5'b10000);
        chk("reset_word", task_word, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: split n512 8..3, alternating addresses
        s0 = start_cnt;
        send_cmd(1'b0, 1'b1, 5'd8, 5'd3, 1'b1, 1'b1, {A, B, C});
        do_task("t1_k0", w(5'd8, 3'd4, 1'b0, 1'b1, A, B, C), 1'b0, 1'b0);
        do_task("t1_k1", w(5'd7, 3'd4, 1'b0, 1'b0, C, B, A), 1'b0, 1'b0);
        do_task("t1_k2", w(5'd6, 3'd4, 1'b0, 1'b0, A, B, C), 1'b0, 1'b0);
        do_task("t1_k3", w(5'd5, 3'd4, 1'b0, 1'b0, C, B, A), 1'b0, 1'b0);
        do_task("t1_k4", w(5'd4, 3'd4, 1'b0, 1'b0, A, B, C), 1'b0, 1'b0);
        do_task("t1_k5", w(5'd3, 3'd4, 1'b1, 1'b0, C, B, A), 1'b1, 1'b0);
        tick();
        chk("t1_idle", {cmd_ready, busy, job_done}, 3'b100);
        chk("t1_starts", start_cnt - s0, 6);

        // 2: single-stage merge n256
        s0 = start_cnt;
        send_cmd(1'b1, 1'b0, 5'd2, 5'd2, 1'b1, 1'b1, {B, C, A});
        do_task("t2_k0", w(5'd2, 3'd3, 1'b1, 1'b1, B, C, A), 1'b1, 1'b0);
        tick();
        chk("t2_starts", start_cnt - s0, 1);

        // 3: illegal command (hi=8 without n512)
        s0 = start_cnt;
        send_cmd(1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0, {A, B, C});
        chk("t3_err", {job_err, task_start, cmd_ready}, 3'b100);
        tick();
        chk("t3_back_idle", {job_err, cmd_ready, busy}, 3'b010);
        chk("t3_starts", start_cnt - s0, 0);

        // 4: op_done never arrives
        s0 = start_cnt;
        send_cmd(1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, {A, B, C});
        wait_start("t4");
        repeat (15) tick();
        chk("t4_no_err_early", job_err, 0);
        tick();
        chk("t4_err", {job_err, task_start, job_done}, 3'b100);
        tick();
        chk("t4_idle", {cmd_ready, busy, job_err}, 3'b100);
        chk("t4_starts", start_cnt - s0, 1);

        // 5: spurious op_done in IDLE and GAP; cmd_valid held through a job
        task_done = 1'b1;
        tick();
        chk("t5_idle_spur", {cmd_ready, busy, task_start}, 3'b100);
        task_done = 1'b0;
        s0 = start_cnt;
        hold_valid = 1'b1;
        send_cmd(1'b0, 1'b1, 5'd5, 5'd4, 1'b0, 1'b0, {A, B, C});
        do_task("t5_k0", w(5'd5, 3'd4, 1'b0, 1'b0, A, B, C), 1'b0, 1'b1);
        do_task("t5_k1", w(5'd4, 3'd4, 1'b0, 1'b0, C, B, A), 1'b1, 1'b0);
        chk("t5_held_off", cmd_ready, 0);
        chk("t5_starts_job1", start_cnt - s0, 2);
        tick();
        chk("t5_ready_after_done", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        hold_valid = 1'b0;
        do_task("t5_j2_k0", w(5'd5, 3'd4, 1'b0, 1'b0, A, B, C), 1'b0, 1'b0);
        do_task("t5_j2_k1", w(5'd4, 3'd4, 1'b0, 1'b0, C, B, A), 1'b1, 1'b0);
        tick();

        // 6: async reset in WAIT of task 3, then a fresh job
        send_cmd(1'b0, 1'b1, 5'd8, 5'd2, 1'b0, 1'b0, {A, B, C});
        do_task("t6_k0", w(5'd8, 3'd4, 1'b0, 1'b0, A, B, C), 1'b0, 1'b0);
        do_task("t6_k1", w(5'd7, 3'd4, 1'b0, 1'b0, C, B, A), 1'b0, 1'b0);
        do_task("t6_k2", w(5'd6, 3'd4, 1'b0, 1'b0, A, B, C), 1'b0, 1'b0);
        wait_start("t6_k3");
        chk("t6_k3_word", task_word, w(5'd5, 3'd4, 1'b0, 1'b0, C, B, A));
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {cmd_ready, task_start, busy, job_done, job_err}, 5'b10000);
        chk("t6_rst_word", task_word, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_after_rst", {job_done, job_err, cmd_ready}, 3'b001);
        s0 = start_cnt;
        send_cmd(1'b1, 1'b1, 5'd3, 5'd1, 1'b0, 1'b1, {A, B, C});
        do_task("t6_j2_k0", w(5'd1, 3'd5, 1'b0, 1'b0, A, B, C), 1'b0, 1'b0);
        do_task("t6_j2_k1", w(5'd2, 3'd5, 1'b0, 1'b0, C, B, A), 1'b0, 1'b0);
        do_task("t6_j2_k2", w(5'd3, 3'd5, 1'b1, 1'b0, A, B, C), 1'b1, 1'b0);
        tick();
        chk("t6_j2_starts", start_cnt - s0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
